// File: rtl/iigs_pkg.sv
// Shared IIgs definitions: SHADOW register bit indices, shadowed video region
// bounds, slowram replay entry width and the drain FSM state encoding.
package iigs_pkg;

    // SHADOW ($C035) bit positions; a set bit inhibits shadowing of that region
    localparam int SH_TXT1   = 0;
    localparam int SH_HGR1   = 1;
    localparam int SH_HGR2   = 2;
    localparam int SH_SHR    = 3;
    localparam int SH_AUXHGR = 4;
    localparam int SH_TXT2   = 5;

    // Shadowed video regions (inclusive bounds) within banks $00/$01
    localparam logic [15:0] TXT1_LO = 16'h0400;
    localparam logic [15:0] TXT1_HI = 16'h07FF;
    localparam logic [15:0] TXT2_LO = 16'h0800;
    localparam logic [15:0] TXT2_HI = 16'h0BFF;
    localparam logic [15:0] HGR1_LO = 16'h2000;
    localparam logic [15:0] HGR1_HI = 16'h3FFF;
    localparam logic [15:0] HGR2_LO = 16'h4000;
    localparam logic [15:0] HGR2_HI = 16'h5FFF;
    localparam logic [15:0] SHR_LO  = 16'h2000;
    localparam logic [15:0] SHR_HI  = 16'h9FFF;

    // Replay entry: {bank[0], addr[15:0], data[7:0]}
    localparam int SR_ENTRY_W = 25;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } drain_state_t;

    // Inclusive address range test
    function automatic logic addr_in(input logic [15:0] a,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO. The caller qualifies push/pop; the head entry is
// presented combinationally so a pop can capture it on the same edge.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 25
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;

    // Storage array; no reset needed since level gates every read
    always_ff @(posedge clk_sys) begin
        if (push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   r_level <= r_level + ONE_L;
                2'b01:   r_level <= r_level - ONE_L;
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = r_mem[r_rptr];
    assign level = r_level;
    assign full  = (r_level == DEPTH_L);
    assign empty = (r_level == '0);

endmodule

// File: rtl/shadow_write_buffer.sv
// Shadow write buffer: captures CPU writes into shadowed video regions of
// banks $00/$01 and replays them into slowram ($E0/$E1) one per slow slot.
module shadow_write_buffer
    import iigs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cpu_ce,
    input  logic [7:0]    bank,
    input  logic [15:0]   addr,
    input  logic [7:0]    dout,
    input  logic          we,
    input  logic [7:0]    shadow,
    input  logic          slow_tick,
    input  logic          cpu_slow_busy,
    output logic [16:0]   sr_addr,
    output logic [7:0]    sr_din,
    output logic          sr_we,
    output logic          sr_ce,
    output logic          stall,
    output logic          overflow,
    output logic [AW:0]   level
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    logic                  w_hit;
    logic                  w_cap;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [AW:0]           w_level;
    logic [AW:0]           w_level_nxt;
    logic [SR_ENTRY_W-1:0] w_head;
    logic                  w_unused_shadow;

    drain_state_t          r_state;
    logic [16:0]           r_sr_addr;
    logic [7:0]            r_sr_din;
    logic                  r_sr_we;
    logic                  r_stall;
    logic                  r_overflow;

    // SHADOW bits 7:6 control other features and are not decoded here
    assign w_unused_shadow = ^shadow[7:6];

    // Shadow hit decode; aux hires inhibit only affects bank $01
    always_comb begin
        w_hit = 1'b0;
        if ((bank == 8'h00) || (bank == 8'h01)) begin
            w_hit = (addr_in(addr, TXT1_LO, TXT1_HI) && !shadow[SH_TXT1])
                 || (addr_in(addr, TXT2_LO, TXT2_HI) && !shadow[SH_TXT2])
                 || (addr_in(addr, HGR1_LO, HGR1_HI) && !shadow[SH_HGR1]
                     && (!bank[0] || !shadow[SH_AUXHGR]))
                 || (addr_in(addr, HGR2_LO, HGR2_HI) && !shadow[SH_HGR2]
                     && (!bank[0] || !shadow[SH_AUXHGR]))
                 || (bank[0] && addr_in(addr, SHR_LO, SHR_HI) && !shadow[SH_SHR]);
        end else begin
            w_hit = 1'b0;
        end
    end

    // A pop frees a slot on the same edge, so a full queue still accepts
    // a capture when it is draining at that moment
    assign w_cap  = cpu_ce & we & w_hit;
    assign w_pop  = (r_state == ST_IDLE) & slow_tick & !w_empty & !cpu_slow_busy;
    assign w_push = w_cap & (!w_full | w_pop);

    // Occupancy after this edge, used to register stall in step with level
    always_comb begin
        w_level_nxt = w_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = w_level + ONE_L;
            2'b01:   w_level_nxt = w_level - ONE_L;
            default: w_level_nxt = w_level;
        endcase
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (SR_ENTRY_W)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     ({bank[0], addr, dout}),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    // Drain FSM: pop into the output registers, strobe for exactly one cycle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_sr_addr <= 17'h00000;
            r_sr_din  <= 8'h00;
            r_sr_we   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_sr_addr <= w_head[24:8];
                        r_sr_din  <= w_head[7:0];
                        r_sr_we   <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_sr_we   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_sr_we <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sr_we <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall mirrors full; overflow latches any capture dropped for lack of room
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_stall <= (w_level_nxt == DEPTH_L);
            if (w_cap && !w_push) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    assign sr_addr  = r_sr_addr;
    assign sr_din   = r_sr_din;
    assign sr_we    = r_sr_we;
    assign sr_ce    = r_sr_we;
    assign stall    = r_stall;
    assign overflow = r_overflow;
    assign level    = w_level;

endmodule

// File: tb/tb_shadow_write_buffer.sv
// Self-checking bench for shadow_write_buffer: decode table, scoreboarded
// replay, full/overflow, contention, burst ordering and reset mid-drain.
module tb_shadow_write_buffer;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_ce = 1'b0;
    logic [7:0]  bank = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  shadow = 8'h00;
    logic        slow_tick = 1'b0;
    logic        cpu_slow_busy = 1'b0;
    logic [16:0] sr_addr;
    logic [7:0]  sr_din;
    logic        sr_we;
    logic        sr_ce;
    logic        stall;
    logic        overflow;
    logic [3:0]  level;

    shadow_write_buffer #(.DEPTH(8), .AW(3)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .cpu_ce        (cpu_ce),
        .bank          (bank),
        .addr          (addr),
        .dout          (dout),
        .we            (we),
        .shadow        (shadow),
        .slow_tick     (slow_tick),
        .cpu_slow_busy (cpu_slow_busy),
        .sr_addr       (sr_addr),
        .sr_din        (sr_din),
        .sr_we         (sr_we),
        .sr_ce         (sr_ce),
        .stall         (stall),
        .overflow      (overflow),
        .level         (level)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;
    int exp_pulse = 0;
    logic prev_we = 1'b0;
    logic [24:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Output monitor: every strobe must match the oldest expected entry
    always @(negedge clk_sys) begin
        logic [24:0] e;
        if (reset_n && sr_we) begin
            n_pulse++;
            chk("sr_ce_eq_we", {31'd0, sr_ce}, 32'd1);
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_sr_we", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sr_addr", {15'd0, sr_addr}, {15'd0, e[24:8]});
                chk("sr_din", {24'd0, sr_din}, {24'd0, e[7:0]});
            end
        end
        prev_we = reset_n & sr_we;
    end

    task automatic cpu_write(input logic [7:0] b, input logic [15:0] a,
                             input logic [7:0] d, input logic w, input logic exp_push);
        @(negedge clk_sys);
        bank = b; addr = a; dout = d; we = w; cpu_ce = 1'b1;
        if (exp_push) sb.push_back({b[0], a, d});
        @(negedge clk_sys);
        cpu_ce = 1'b0; we = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk_sys);
        slow_tick = 1'b1;
        @(negedge clk_sys);
        slow_tick = 1'b0;
        @(negedge clk_sys);
    endtask

    typedef struct {
        logic [7:0]  bank;
        logic [15:0] addr;
        logic [7:0]  shadow;
        logic        we;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{8'h00, 16'h0400, 8'h00, 1'b1, 1'b1};
        vecs[1]  = '{8'h00, 16'h0500, 8'h01, 1'b1, 1'b0};
        vecs[2]  = '{8'h01, 16'h6000, 8'h08, 1'b1, 1'b0};
        vecs[3]  = '{8'h01, 16'h2000, 8'h10, 1'b1, 1'b1};
        vecs[4]  = '{8'h01, 16'h2000, 8'h18, 1'b1, 1'b0};
        vecs[5]  = '{8'h02, 16'h0400, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{8'h00, 16'h0800, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{8'h00, 16'h0800, 8'h20, 1'b1, 1'b0};
        vecs[8]  = '{8'h00, 16'h2000, 8'h10, 1'b1, 1'b1};
        vecs[9]  = '{8'h00, 16'h4000, 8'h04, 1'b1, 1'b0};
        vecs[10] = '{8'h01, 16'h5FFF, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{8'h01, 16'h9FFF, 8'h00, 1'b1, 1'b1};
        vecs[12] = '{8'h00, 16'h9FFF, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{8'h00, 16'h0C00, 8'h00, 1'b1, 1'b0};
        vecs[14] = '{8'h00, 16'h03FF, 8'h00, 1'b1, 1'b0};
        vecs[15] = '{8'h00, 16'h07FF, 8'h00, 1'b1, 1'b1};
        vecs[16] = '{8'h01, 16'hA000, 8'h00, 1'b1, 1'b0};
        vecs[17] = '{8'h00, 16'h0400, 8'hC0, 1'b1, 1'b1};
        vecs[18] = '{8'h00, 16'h0400, 8'h00, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_sr_we", {31'd0, sr_we}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("rel_level", {28'd0, level}, 32'd0);
        chk("rel_sr_we", {31'd0, sr_we}, 32'd0);
        chk("rel_sr_ce", {31'd0, sr_ce}, 32'd0);
        chk("rel_sr_addr", {15'd0, sr_addr}, 32'd0);
        chk("rel_sr_din", {24'd0, sr_din}, 32'd0);
        chk("rel_stall", {31'd0, stall}, 32'd0);
        chk("rel_overflow", {31'd0, overflow}, 32'd0);

        // Decode table: each write then a drain tick
        for (int i = 0; i < 19; i++) begin
            shadow = vecs[i].shadow;
            cpu_write(vecs[i].bank, vecs[i].addr, (i == 0) ? 8'hAB : 8'(8'h40 + i),
                      vecs[i].we, vecs[i].exp_hit);
            chk($sformatf("decode_level_%0d", i), {28'd0, level}, {31'd0, vecs[i].exp_hit});
            if (vecs[i].exp_hit) exp_pulse++;
            tick();
            chk($sformatf("drain_level_%0d", i), {28'd0, level}, 32'd0);
            chk($sformatf("pulses_%0d", i), n_pulse, exp_pulse);
        end

        // Fill to full with no slow ticks
        shadow = 8'h00;
        for (int i = 0; i < 8; i++) cpu_write(8'h00, 16'h0400 + 16'(i), 8'(8'h80 + i), 1'b1, 1'b1);
        chk("full_level", {28'd0, level}, 32'd8);
        chk("full_stall", {31'd0, stall}, 32'd1);
        chk("full_ovf", {31'd0, overflow}, 32'd0);

        // Busy slow slot: no drain
        cpu_slow_busy = 1'b1;
        tick();
        cpu_slow_busy = 1'b0;
        chk("busy_level", {28'd0, level}, 32'd8);
        chk("busy_pulses", n_pulse, exp_pulse);

        // Push and pop on the same edge while full
        @(negedge clk_sys);
        bank = 8'h01; addr = 16'h3000; dout = 8'h5A; we = 1'b1; cpu_ce = 1'b1; slow_tick = 1'b1;
        sb.push_back({1'b1, 16'h3000, 8'h5A});
        exp_pulse++;
        @(negedge clk_sys);
        cpu_ce = 1'b0; we = 1'b0; slow_tick = 1'b0;
        chk("pushpop_level", {28'd0, level}, 32'd8);
        chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk_sys);

        // Ninth write while full is dropped
        cpu_write(8'h00, 16'h0700, 8'hEE, 1'b1, 1'b0);
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        chk("drop_level", {28'd0, level}, 32'd8);

        // Drain everything in order
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_pulse++;
        end
        chk("drained_level", {28'd0, level}, 32'd0);
        chk("drained_stall", {31'd0, stall}, 32'd0);
        chk("drained_pulses", n_pulse, exp_pulse);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Burst on consecutive cycles, then a two-cycle tick drains only one
        @(negedge clk_sys);
        bank = 8'h01; we = 1'b1; cpu_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 16'h2000 + 16'(i);
            dout = 8'(8'h11 * (i + 1));
            sb.push_back({1'b1, addr, dout});
            @(negedge clk_sys);
        end
        cpu_ce = 1'b0; we = 1'b0;
        chk("burst_level", {28'd0, level}, 32'd3);
        slow_tick = 1'b1;
        repeat (2) @(negedge clk_sys);
        slow_tick = 1'b0;
        @(negedge clk_sys);
        exp_pulse++;
        chk("long_tick_level", {28'd0, level}, 32'd2);
        tick(); tick();
        exp_pulse += 2;
        chk("burst_pulses", n_pulse, exp_pulse);
        chk("burst_sb_empty", sb.size(), 32'd0);

        // Reset in the middle of an ISSUE cycle
        cpu_write(8'h00, 16'h0400, 8'h77, 1'b1, 1'b1);
        cpu_write(8'h00, 16'h0401, 8'h78, 1'b1, 1'b1);
        @(negedge clk_sys);
        slow_tick = 1'b1;
        @(posedge clk_sys);
        #1 slow_tick = 1'b0;
        chk("issue_we", {31'd0, sr_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_we", {31'd0, sr_we}, 32'd0);
        chk("rst_mid_ce", {31'd0, sr_ce}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("rst_mid_level", {28'd0, level}, 32'd0);
        chk("rst_mid_ovf", {31'd0, overflow}, 32'd0);
        tick();
        chk("no_drain_after_rst", n_pulse, exp_pulse);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
